uart_rx_16x: RTL and testbench

Asynchronous serial receiver, 8N1 framing, LSB first, 16x oversampling. It is the receive end of the team's serial link: it deserializes the line driven by the PISO-style transmitter into bytes. It presents each byte through a level ready/ack handshake, with frame-error and overrun status.

---
 rtl/uart_rx_16x.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_16x.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 8N1 serial receiver, LSB first, 16x oversampling.
// Bytes are offered through a level ready/ack handshake with one-cycle
// valid and frame-error pulses and a sticky overrun flag.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to the middle of the start bit to confirm it
// DATA      | sampling 8 data bits at their middles, LSB first
// STOP      | counting to the middle of the stop bit
// WAIT_HIGH | stop bit sampled low; waiting for the line to return high
module uart_rx_16x #(
    parameter int BAUD_DIV = 54
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int OVS = 16;
    localparam int PW  = $clog2(BAUD_DIV);

    localparam logic [PW-1:0] PRESC_TOP = PW'(BAUD_DIV - 1);
    localparam logic [3:0]    TICK_TOP  = 4'(OVS - 1);
    localparam logic [3:0]    MID_START = 4'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign tick = (presc == PRESC_TOP);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Oversample prescaler; restarted on the detected start edge so that
    // tick phase is aligned to the edge rather than free-running.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc <= '0;
        end else if ((state == IDLE) && !rx_s) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Frame FSM with registered status outputs and the ready/ack handshake.
    // The load in STOP is written after the ack clear so that a load in
    // the same cycle as rd_ack wins.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (rd_ack) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == MID_START) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == TICK_TOP) begin
                            shift <= {rx_s, shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == TICK_TOP) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                rx_data  <= shift;
                                rx_ready <= 1'b1;
                                rx_valid <= 1'b1;
                                if (rx_ready && !rd_ack) begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                state     <= WAIT_HIGH;
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: self-checking bench for uart_rx_16x with a frame-level
// reference model (expected-event queue plus ready/overrun bookkeeping).
module tb_uart_rx_16x;

    localparam int BD      = 4;
    localparam int BIT_CYC = 16 * BD;
    // Cycle (relative to driving the start bit) whose following edge is the load edge:
    // 2 synchronizer flops + 1 detect edge + 152 ticks, minus the first edge.
    localparam int ACK_C   = 2 + 152 * BD;
    localparam int LAT     = 3 + 152 * BD;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       rx;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = -1;
    int ferr_cyc = -1;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  cur_ev;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    logic       m_ready = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;

    uart_rx_16x #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .rx        (rx),
        .rd_ack    (rd_ack),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every valid/frame-error pulse must match the next
    // expected frame event, and pulses must be exactly one cycle long.
    always @(negedge clk) begin
        if (!reset_p) begin
            if (rx_valid) begin
                valid_cyc = cyc;
                check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
                check("valid_no_ferr", {31'd0, frame_err}, 32'd0);
                if (exp_q.size() == 0 || exp_q[0].ferr) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid: got data 0x%0h, no good frame expected", rx_data);
                end else begin
                    cur_ev = exp_q.pop_front();
                    check("rx_data_vs_model", {24'd0, rx_data}, {24'd0, cur_ev.data});
                    check("rx_ready_at_load", {31'd0, rx_ready}, 32'd1);
                end
            end
            if (frame_err) begin
                ferr_cyc = cyc;
                check("ferr_one_cycle", {31'd0, prev_ferr}, 32'd0);
                if (exp_q.size() == 0 || !exp_q[0].ferr) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_err: got 1, no bad frame expected");
                end else begin
                    cur_ev = exp_q.pop_front();
                end
            end
            prev_valid = rx_valid;
            prev_ferr  = frame_err;
        end else begin
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int stop_cyc, input bit ack_at_load);
        logic [9:0] line;
        ev_t        ev;
        int         idx;
        line    = {stop_bit, b, 1'b0};
        ev.ferr = !stop_bit;
        ev.data = b;
        exp_q.push_back(ev);
        start_cyc = cyc;
        for (int c = 0; c < 9 * BIT_CYC + stop_cyc; c++) begin
            idx    = (c / BIT_CYC > 9) ? 9 : c / BIT_CYC;
            rx     = line[idx];
            rd_ack = ack_at_load && (c == ACK_C);
            step();
        end
        rd_ack = 1'b0;
        if (stop_bit) begin
            m_ovr   = ack_at_load ? 1'b0 : (m_ovr | m_ready);
            m_ready = 1'b1;
            m_data  = b;
        end else if (ack_at_load) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) break;
            step();
        end
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_pending_events"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, m_data});
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, m_ready});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    initial begin
        logic [9:0] pline;
        logic [7:0] rb;
        bit         ack_ld;
        bit         bad;

        reset_p = 1'b1;
        rx      = 1'b1;
        rd_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_p = 1'b0;
        step();
        step();

        // 1: single good frame 0xA5
        valid_cyc = -1;
        send_frame(8'hA5, 1'b1, BIT_CYC, 1'b0);
        check("t1_latency", valid_cyc - start_cyc, LAT);
        check("t1_data_lit", {24'd0, rx_data}, 32'h0000_00A5);
        check("t1_ready_lit", {31'd0, rx_ready}, 32'd1);
        check("t1_ferr_lit", {31'd0, frame_err}, 32'd0);
        idle(8);
        wait_idle("t1", 50);
        check_model("t1");

        // 2: 0.25-bit glitch is rejected
        rx = 1'b0;
        repeat (8) step();
        check("t2_busy_in_start", {31'd0, busy}, 32'd1);
        repeat (8) step();
        idle(100);
        wait_idle("t2", 50);
        check_model("t2");

        // 3: framing error with line held low, then recovery
        ack();
        ferr_cyc = -1;
        send_frame(8'h3C, 1'b0, 2 * BIT_CYC, 1'b0);
        check("t3_ferr_latency", ferr_cyc - start_cyc, LAT);
        check("t3_busy_wait_high", {31'd0, busy}, 32'd1);
        check("t3_ready_lit", {31'd0, rx_ready}, 32'd0);
        check("t3_data_unchanged", {24'd0, rx_data}, 32'h0000_00A5);
        idle(16);
        wait_idle("t3a", 50);
        send_frame(8'h55, 1'b1, BIT_CYC, 1'b0);
        idle(8);
        check("t3_next_data_lit", {24'd0, rx_data}, 32'h0000_0055);
        check_model("t3");

        // 4: back-to-back frames without ack cause overrun
        ack();
        send_frame(8'h11, 1'b1, BIT_CYC, 1'b0);
        send_frame(8'h22, 1'b1, BIT_CYC, 1'b0);
        idle(8);
        check("t4_data_lit", {24'd0, rx_data}, 32'h0000_0022);
        check("t4_ready_lit", {31'd0, rx_ready}, 32'd1);
        check("t4_overrun_lit", {31'd0, overrun}, 32'd1);
        check_model("t4a");
        ack();
        check("t4_ready_cleared", {31'd0, rx_ready}, 32'd0);
        check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);

        // 5: ack coinciding with a load while ready is set
        send_frame(8'h42, 1'b1, BIT_CYC, 1'b0);
        send_frame(8'h7E, 1'b1, BIT_CYC, 1'b1);
        idle(8);
        check("t5_ready_lit", {31'd0, rx_ready}, 32'd1);
        check("t5_overrun_lit", {31'd0, overrun}, 32'd0);
        check("t5_data_lit", {24'd0, rx_data}, 32'h0000_007E);
        check_model("t5");

        // 6: reset in the middle of data bit 4 of 0xFF
        pline = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 5 * BIT_CYC + BIT_CYC / 2; c++) begin
            rx = pline[c / BIT_CYC];
            step();
        end
        #2;
        reset_p = 1'b1;
        #1;
        check("t6_rx_data", {24'd0, rx_data}, 32'd0);
        check("t6_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("t6_frame_err", {31'd0, frame_err}, 32'd0);
        check("t6_overrun", {31'd0, overrun}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
        exp_q.delete();
        rx = 1'b1;
        repeat (3) step();
        reset_p = 1'b0;
        step();
        send_frame(8'h81, 1'b1, BIT_CYC, 1'b0);
        idle(8);
        check("t6_data_lit", {24'd0, rx_data}, 32'h0000_0081);
        check_model("t6");

        // Randomized frames, acks and occasional framing errors
        for (int i = 0; i < 24; i++) begin
            rb     = 8'($urandom);
            bad    = ($urandom_range(0, 5) == 0);
            ack_ld = !bad && ($urandom_range(0, 3) == 0);
            if (bad) begin
                send_frame(rb, 1'b0, BIT_CYC, 1'b0);
            end else begin
                send_frame(rb, 1'b1, BIT_CYC, ack_ld);
            end
            idle(4 + $urandom_range(0, 40));
            wait_idle("rnd", 50);
            check_model("rnd");
            if ($urandom_range(0, 1) == 1) ack();
        end

        idle(20);
        check("final_pending_events", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
